// File: rtl/design_32_result_fifo_if.sv
// ---------------------------------------------------------------------------
// design_32_result_fifo_if
//   Handshake bundle between the design_32 producer, the result FIFO and the
//   downstream consumer.
//
//   in_valid  : producer result valid
//   in_data   : producer result word (W bits)
//   out_valid : FIFO head entry available
//   out_ready : consumer accepts the head entry this cycle
//   out_data  : FIFO head entry (W bits)
//
//   modport master : the side that produces results and consumes the FIFO
//                    output (testbench / surrounding datapath)
//   modport slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface design_32_result_fifo_if #(
  parameter int W = 12
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/design_32_result_fifo.sv
// ---------------------------------------------------------------------------
// design_32_result_fifo
//   Small synchronous FIFO that captures design_32 result words and presents
//   them to a possibly stalling consumer with a show-ahead valid/ready read.
//   Reports occupancy and a sticky overflow flag for words that arrive with
//   no room left.
//
//   Optional build macro: DESIGN_32_RESULT_FIFO_CKSUM_EN
//     defined   : cksum is a running rotate-left-by-1-then-XOR checksum of
//                 every accepted word
//     undefined : cksum is tied to zero, no checksum register exists
//
//   Ports
//     clk      : clock, all state on the rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : handshake bundle (slave modport)
//                  in_valid/in_data   producer side
//                  out_valid/out_ready/out_data consumer side
//     clr      : synchronous flush, overrides push/pop in the same cycle
//     count    : occupancy 0..DEPTH
//     full     : count == DEPTH
//     empty    : count == 0
//     overflow : sticky, a word was dropped since the last clr/reset
//     cksum    : running checksum of accepted words (0 when disabled)
// ---------------------------------------------------------------------------
module design_32_result_fifo #(
  parameter  int W     = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  design_32_result_fifo_if.slave  bus,
  input  logic                    clr,
  output logic [AW:0]             count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [W-1:0]            cksum
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          push;
  logic          drop;
  logic          mem_we;

  // -------------------------------------------------------------------------
  // Status and read side
  // -------------------------------------------------------------------------
  // full/empty come from the occupancy counter so that the pointers can be
  // only AW bits wide and still distinguish full from empty.
  assign full          = (count_q == CNT_FULL);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign overflow      = overflow_q;

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem_q[rd_ptr_q];

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a
  // push when the consumer is draining.
  assign pop    = bus.out_valid & bus.out_ready;
  assign push   = bus.in_valid & (~full | pop);
  assign drop   = bus.in_valid & ~push;
  assign mem_we = push & ~clr;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (clr) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Optional checksum
  // -------------------------------------------------------------------------
`ifdef DESIGN_32_RESULT_FIFO_CKSUM_EN
  logic [W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (clr) begin
      cksum_d = '0;
    end else if (push) begin
      cksum_d = {cksum_q[W-2:0], cksum_q[W-1]} ^ bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_design_32_result_fifo.sv
module tb_design_32_result_fifo;

  localparam int W = 12;

  typedef struct {
    logic          iv;
    logic [W-1:0]  d;
    logic          rdy;
    logic          clr;
    logic          push_ok;
    logic [2:0]    ecnt;
    logic [W-1:0]  ed;
    logic          eovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic [W-1:0] cksum;

  int n_checks = 0;
  int n_errors = 0;

  vec_t         vecs[$];
  logic [W-1:0] ck_model;

  design_32_result_fifo_if #(.W(W)) bus ();

  design_32_result_fifo #(.W(W), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr      (clr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .cksum    (cksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [W-1:0] d, input logic rdy,
                     input logic c, input logic pok, input logic [2:0] ecnt,
                     input logic [W-1:0] ed, input logic eovf);
    vec_t v;
    v.iv = iv; v.d = d; v.rdy = rdy; v.clr = c; v.push_ok = pok;
    v.ecnt = ecnt; v.ed = ed; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic rdy, input logic c);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clr           = c;
  endtask

  function automatic logic [W-1:0] exp_cksum();
`ifdef DESIGN_32_RESULT_FIFO_CKSUM_EN
    return ck_model;
`else
    return '0;
`endif
  endfunction

  initial begin
    // ---------------- vector table ----------------
    //   iv  data     rdy clr pok cnt head     ovf
    add(0, 12'h000, 0, 0, 0, 3'd0, 12'h000, 0);   // idle after reset
    add(1, 12'h001, 0, 0, 1, 3'd1, 12'h001, 0);   // 1-cycle latency
    add(1, 12'h002, 0, 0, 1, 3'd2, 12'h001, 0);
    add(1, 12'h003, 0, 0, 1, 3'd3, 12'h001, 0);   // stall holds head
    add(0, 12'h000, 1, 0, 0, 3'd2, 12'h002, 0);
    add(0, 12'h000, 1, 0, 0, 3'd1, 12'h003, 0);
    add(0, 12'h000, 1, 0, 0, 3'd0, 12'h000, 0);
    add(0, 12'h000, 1, 0, 0, 3'd0, 12'h000, 0);   // ready while empty ignored
    add(1, 12'h0A0, 0, 0, 1, 3'd1, 12'h0A0, 0);
    add(1, 12'h0A1, 0, 0, 1, 3'd2, 12'h0A0, 0);
    add(1, 12'h0A2, 0, 0, 1, 3'd3, 12'h0A0, 0);
    add(1, 12'h0A3, 0, 0, 1, 3'd4, 12'h0A0, 0);   // full
    add(1, 12'hABC, 0, 0, 0, 3'd4, 12'h0A0, 1);   // dropped
    add(1, 12'hDEF, 1, 0, 1, 3'd4, 12'h0A1, 1);   // push+pop while full
    add(0, 12'h000, 1, 0, 0, 3'd3, 12'h0A2, 1);
    add(0, 12'h000, 1, 0, 0, 3'd2, 12'h0A3, 1);
    add(0, 12'h000, 1, 0, 0, 3'd1, 12'hDEF, 1);   // tail is 0xDEF
    add(0, 12'h000, 1, 0, 0, 3'd0, 12'h000, 1);   // overflow sticky
    for (int k = 0; k < 10; k++)
      add(1, W'(12'h100 + k), 1, 0, 1, 3'd1, W'(12'h100 + k), 1);
    add(0, 12'h000, 1, 0, 0, 3'd0, 12'h000, 1);
    add(1, 12'h201, 0, 0, 1, 3'd1, 12'h201, 1);
    add(1, 12'h202, 0, 0, 1, 3'd2, 12'h201, 1);
    add(1, 12'h203, 0, 0, 1, 3'd3, 12'h201, 1);
    add(1, 12'h2FF, 1, 1, 0, 3'd0, 12'h000, 0);   // clr beats push/pop
    add(0, 12'h000, 0, 0, 0, 3'd0, 12'h000, 0);   // incoming word discarded
    add(1, 12'h001, 0, 0, 1, 3'd1, 12'h001, 0);   // cksum 0x001
    add(1, 12'h800, 0, 0, 1, 3'd2, 12'h001, 0);   // cksum 0x802

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(0, '0, 0, 0);
    ck_model = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_empty",     32'(empty),         32'd1);
    check("rst_full",      32'(full),          32'd0);
    check("rst_count",     32'(count),         32'd0);
    check("rst_overflow",  32'(overflow),      32'd0);
    check("rst_cksum",     32'(cksum),         32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // ---------------- table loop ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      @(posedge clk);
      #1;
      if (vecs[i].clr)
        ck_model = '0;
      else if (vecs[i].push_ok)
        ck_model = {ck_model[W-2:0], ck_model[W-1]} ^ vecs[i].d;
      check($sformatf("v%0d_count", i),     32'(count),         32'(vecs[i].ecnt));
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ecnt != 0));
      check($sformatf("v%0d_full", i),      32'(full),          32'(vecs[i].ecnt == 3'd4));
      check($sformatf("v%0d_empty", i),     32'(empty),         32'(vecs[i].ecnt == 3'd0));
      check($sformatf("v%0d_overflow", i),  32'(overflow),      32'(vecs[i].eovf));
      check($sformatf("v%0d_cksum", i),     32'(cksum),         32'(exp_cksum()));
      if (vecs[i].ecnt != 0)
        check($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
    end

    // Hand-computed checksum after pushing 0x001 then 0x800 post-clr.
`ifdef DESIGN_32_RESULT_FIFO_CKSUM_EN
    check("cksum_final", 32'(cksum), 32'h802);
`else
    check("cksum_final", 32'(cksum), 32'h000);
`endif

    // ---------------- async reset mid-stream ----------------
    drive(0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count",     32'(count),         32'd0);
    check("midrst_empty",     32'(empty),         32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_cksum",     32'(cksum),         32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    drive(1, 12'h3AA, 0, 0);
    @(posedge clk);
    #1;
    check("postrst_out_valid", 32'(bus.out_valid), 32'd1);
    check("postrst_out_data",  32'(bus.out_data),  32'h3AA);
    check("postrst_count",     32'(count),         32'd1);
`ifdef DESIGN_32_RESULT_FIFO_CKSUM_EN
    check("postrst_cksum", 32'(cksum), 32'h3AA);
`else
    check("postrst_cksum", 32'(cksum), 32'h000);
`endif
    drive(0, '0, 1, 0);
    @(posedge clk);
    #1;
    check("postrst_drain_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/design_32_result_fifo.md
Name: design_32_result_fifo

Overview:
- Downstream stage of the design_32 datapath; captures each result word `y` qualified by `valid` into a small synchronous FIFO.
- Presents the stored words to the consumer over a valid/ready handshake (show-ahead read).
- Decouples the fixed-latency producer from a consumer that may stall.
- Reports occupancy and a sticky overflow flag when a result arrives with no space for it.

Parameters:
- W, 12, data width; matches producer result width.
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer result valid (from design_32 `valid`).
- in_data  input  W  producer result (from design_32 `y`).
- clr  input  1  synchronous flush.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  W  head entry.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a result was dropped.
- cksum  output  W  running checksum of accepted words (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): rd_ptr=0, wr_ptr=0, count=0, overflow=0, cksum=0. Resulting outputs: out_valid=0, empty=1, full=0. Memory contents are not reset; out_data is don't-care while empty.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop).
  - When full, a simultaneous pop frees a slot and the push is accepted.
- Empty FIFO: no bypass. A word pushed at edge N is visible at out_data/out_valid after edge N, i.e. 1-cycle latency.
- Show-ahead read:
  - out_data = mem[rd_ptr] combinationally.
  - out_valid = !empty.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Push writes mem[wr_ptr] and advances wr_ptr; pop advances rd_ptr. Both pointers wrap modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: in_valid=1 and push=0 sets overflow=1. The word is discarded; FIFO state is unchanged.
- overflow stays 1 until clr or reset.
- out_ready while empty is ignored; there is no underflow.
- clr (synchronous, highest priority):
  - Next state: pointers=0, count=0, overflow=0, cksum=0.
  - A push or pop in the same cycle is discarded.
- Reset mid-stream: all stored words are lost. The FIFO resumes empty on the first edge after rst_n deasserts.
- full and empty are derived from count, never from pointer comparison.

Optional Feature:
- Macro: DESIGN_32_RESULT_FIFO_CKSUM_EN.
- Defined: on each accepted push, cksum <= {cksum[W-2:0], cksum[W-1]} ^ in_data, i.e. rotate left by 1 then XOR.
  - Dropped words do not update cksum.
  - cksum clears on reset and on clr.
- Undefined: cksum is tied to 0 and no checksum register is built. The port list is identical in both builds.

Test Plan:
- Reset then idle → out_valid=0, empty=1, full=0, count=0, overflow=0, cksum=0.
- Push 0x001,0x002,0x003 on consecutive cycles with out_ready=0 → count=3, out_data=0x001; then out_ready=1 for 3 cycles → pops 0x001,0x002,0x003 in order, empty=1.
- Fill all 4 entries, then push 0xABC with out_ready=0 → word dropped, overflow=1, count=4. Next cycle push 0xDEF with out_ready=1 → accepted, count stays 4, tail entry = 0xDEF.
- Wrap-around: 10 push/pop pairs of values 0x100..0x109 → outputs in order, count never exceeds 1, pointers wrap cleanly.
- With 3 entries stored and overflow=1, assert clr together with in_valid=1 and out_ready=1 → next cycle count=0, overflow=0, empty=1, incoming word discarded.
- CKSUM_EN build, push 0x001 then 0x800 → cksum=0x001 after the first push, then 0x002^0x800=0x802. Non-CKSUM build → cksum stays 0.
